// File: rtl/axilite_axis_pkg.sv
// Shared types and header helpers for the AXI-Lite backend <-> AXI-Stream bridge.
package axilite_axis_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RD_WAIT,
        DRAIN,
        DONE
    } bk_br_state_e;

    localparam int HDR_STRB_MSB = 31;
    localparam int HDR_RW_BIT   = 27;
    localparam int HDR_ADDR_MSB = 14;

    // Header beat: {strb[3:0], rd_wr, 12'b0, addr[14:0]}; reads never carry strobes.
    function automatic logic [31:0] pack_bk_hdr(input logic        rd_wr,
                                                input logic [3:0]  strb,
                                                input logic [14:0] addr);
        logic [31:0] h;
        h                       = '0;
        h[HDR_STRB_MSB -: 4]    = rd_wr ? 4'h0 : strb;
        h[HDR_RW_BIT]           = rd_wr;
        h[HDR_ADDR_MSB:0]       = addr;
        return h;
    endfunction

endpackage

// File: rtl/axilite_bk_axis_bridge.sv
// Serialises AXI-Lite backend requests onto an AXI-Stream master and returns read completions.
// Optional read-completion timeout enabled by defining AXIL_BK_TIMEOUT_EN.
module axilite_bk_axis_bridge
    import axilite_axis_pkg::*;
#(
    parameter int                 TUSER_W        = 2,
    parameter logic [TUSER_W-1:0] TUSER_CFG      = 2'b01,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]        TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic               axi_aclk,
    input  logic               axi_reset,
    input  logic               bk_rd_wr,
    input  logic               bk_valid,
    input  logic [14:0]        bk_addr,
    input  logic [31:0]        bk_wdata,
    input  logic [3:0]         bk_wstrb,
    output logic [31:0]        bk_rdata,
    output logic               bk_ready,
    output logic [31:0]        as_tdata,
    output logic [TUSER_W-1:0] as_tuser,
    output logic               as_tlast,
    output logic               as_tvalid,
    input  logic               as_tready,
    input  logic [31:0]        sa_tdata,
    input  logic [TUSER_W-1:0] sa_tuser,
    input  logic               sa_tlast,
    input  logic               sa_tvalid,
    output logic               sa_tready,
    output logic               rx_err
);

    bk_br_state_e state_q, state_d;
    logic         rd_wr_q;
    logic [14:0]  addr_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;
    logic [31:0]  rdata_q, rdata_d;
    logic         rx_err_q, rx_err_d;
    logic         capture;
    logic         rx_wait;
    logic         tmo_hit;

    logic         unused_tuser;
    assign unused_tuser = ^sa_tuser;

    assign rx_wait = (state_q == RD_WAIT) || (state_q == DRAIN);

`ifdef AXIL_BK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counter restarts on entry to the wait states and on every accepted completion beat.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            cnt_q <= '0;
        end else if (!rx_wait || sa_tvalid) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_DATA ^ 32'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rx_err_d = rx_err_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bk_valid) begin
                    capture = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (as_tready) state_d = rd_wr_q ? RD_WAIT : WDATA;
            end
            WDATA: begin
                if (as_tready) state_d = DONE;
            end
            RD_WAIT: begin
                if (sa_tvalid) begin
                    rdata_d = sa_tdata;
                    if (sa_tlast) begin
                        state_d = DONE;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = DRAIN;
                    end
                end else if (tmo_hit) begin
                    rdata_d  = TIMEOUT_DATA;
                    rx_err_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DRAIN: begin
                // Surplus beats are swallowed; the first beat's data is what gets returned.
                if (sa_tvalid) begin
                    if (sa_tlast) state_d = DONE;
                end else if (tmo_hit) begin
                    rx_err_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q  <= IDLE;
            rd_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rx_err_q <= rx_err_d;
            if (capture) begin
                rd_wr_q <= bk_rd_wr;
                addr_q  <= bk_addr;
                wdata_q <= bk_wdata;
                wstrb_q <= bk_wstrb;
            end
        end
    end

    // Outputs decode only flopped state and frozen request fields, so they are glitch-free and stable.
    assign as_tvalid = (state_q == HDR) || (state_q == WDATA);
    assign as_tdata  = (state_q == WDATA) ? wdata_q
                     : (state_q == HDR)   ? pack_bk_hdr(rd_wr_q, wstrb_q, addr_q)
                     : 32'h0;
    assign as_tlast  = (state_q == WDATA) || ((state_q == HDR) && rd_wr_q);
    assign as_tuser  = as_tvalid ? TUSER_CFG : '0;
    assign sa_tready = rx_wait;
    assign bk_ready  = (state_q == DONE);
    assign bk_rdata  = (state_q == DONE) ? rdata_q : 32'h0;
    assign rx_err    = rx_err_q;

endmodule
